// File: rtl/rx_frame_parser_pkg.sv
// Frame parser shared types: parser states and drop codes.
// Also imported by the tx_frame_builder counterpart.
package rx_frame_parser_pkg;

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DRAIN
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/rx_frame_parser_frame_buffer.sv
// frame_buffer: 2**AW x 8 simple dual-port RAM, sync write, registered read.
// Ports: clk, rst, we/waddr/wdata write side, re/raddr/rdata read side.
module frame_buffer #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only moves on re, so the presented byte stays put
  // while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: pops RxUart bytes, parses SYNC/LEN/payload/CSUM frames,
// buffers payload, releases it on a valid/ready stream once CSUM verifies.
// Ports: clk, rst, x16BaudStrobe; rxData/rxDataPresent/rxRead (RxUart side);
// outData/outValid/outLast/outReady (stream); frameOk/frameErr/errCode.
module rx_frame_parser
  import rx_frame_parser_pkg::*;
#(
  parameter int          LOG2_LEN = 4,
  parameter logic [7:0]  SYNC     = 8'h7E,
  parameter logic [15:0] TIMEOUT  = 16'd320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x16BaudStrobe,
  input  logic [7:0] rxData,
  input  logic       rxDataPresent,
  output logic       rxRead,
  output logic [7:0] outData,
  output logic       outValid,
  output logic       outLast,
  input  logic       outReady,
  output logic       frameOk,
  output logic       frameErr,
  output logic [1:0] errCode
);

  localparam int         W       = LOG2_LEN + 1;
  localparam logic [7:0] MAX_LEN = 8'(2 ** LOG2_LEN);

  state_t          state, nxt;
  logic            pop, pop_q;
  logic [W-1:0]    len_q, len_n;
  logic [W-1:0]    cnt, cnt_n;
  logic [W-1:0]    wp, wp_n;
  logic [W-1:0]    rp, rp_n, rp_inc;
  logic [7:0]      sum, sum_n, sum_add;
  logic [15:0]     tmo, tmo_n;
  logic            ok_q, ok_n;
  logic            err_q, err_n;
  logic [1:0]      code_q, code_n;
  logic            mid, timed_out, last, len_ok;
  logic            we, re;
  logic [LOG2_LEN-1:0] raddr;

  assign mid = (state == S_LEN) || (state == S_PAYLOAD)
            || (state == S_CSUM);
  assign timed_out = mid && (tmo == TIMEOUT);

  // pop_q blocks back-to-back pops so rxDataPresent is always fresh.
  assign pop = !rst && rxDataPresent && !pop_q
            && (state != S_DRAIN) && !timed_out;

  assign sum_add = sum + rxData;
  assign rp_inc  = rp + W'(1);
  assign last    = (rp == len_q - W'(1));
  assign len_ok  = (rxData != 8'd0) && (rxData <= MAX_LEN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_HUNT;
      pop_q  <= 1'b0;
      len_q  <= '0;
      cnt    <= '0;
      wp     <= '0;
      rp     <= '0;
      sum    <= '0;
      tmo    <= '0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      state  <= nxt;
      pop_q  <= pop;
      len_q  <= len_n;
      cnt    <= cnt_n;
      wp     <= wp_n;
      rp     <= rp_n;
      sum    <= sum_n;
      tmo    <= tmo_n;
      ok_q   <= ok_n;
      err_q  <= err_n;
      code_q <= code_n;
    end
  end

  always_comb begin
    nxt    = state;
    len_n  = len_q;
    cnt_n  = cnt;
    wp_n   = wp;
    rp_n   = rp;
    sum_n  = sum;
    ok_n   = 1'b0;
    err_n  = 1'b0;
    code_n = code_q;
    we     = 1'b0;
    re     = 1'b0;
    raddr  = rp[LOG2_LEN-1:0];

    if (!mid || pop) tmo_n = '0;
    else if (x16BaudStrobe && !timed_out) tmo_n = tmo + 16'd1;
    else tmo_n = tmo;

    if (timed_out) begin
      nxt    = S_HUNT;
      err_n  = 1'b1;
      code_n = ERR_TIMEOUT;
      tmo_n  = '0;
    end else begin
      unique case (state)
        S_HUNT: begin
          if (pop && rxData == SYNC) nxt = S_LEN;
        end
        S_LEN: begin
          if (pop) begin
            if (len_ok) begin
              nxt   = S_PAYLOAD;
              sum_n = rxData;
              cnt_n = rxData[W-1:0];
              len_n = rxData[W-1:0];
              wp_n  = '0;
              rp_n  = '0;
            end else begin
              nxt    = S_HUNT;
              err_n  = 1'b1;
              code_n = ERR_LEN;
            end
          end
        end
        S_PAYLOAD: begin
          if (pop) begin
            we    = 1'b1;
            wp_n  = wp + W'(1);
            sum_n = sum_add;
            cnt_n = cnt - W'(1);
            if (cnt == W'(1)) nxt = S_CSUM;
          end
        end
        S_CSUM: begin
          if (pop) begin
            if (sum_add == 8'd0) begin
              nxt   = S_DRAIN;
              ok_n  = 1'b1;
              // Prefetch byte 0 so outData is ready with outValid.
              re    = 1'b1;
              raddr = '0;
            end else begin
              nxt    = S_HUNT;
              err_n  = 1'b1;
              code_n = ERR_CSUM;
            end
          end
        end
        S_DRAIN: begin
          if (outReady) begin
            if (last) begin
              nxt = S_HUNT;
            end else begin
              rp_n  = rp_inc;
              re    = 1'b1;
              raddr = rp_inc[LOG2_LEN-1:0];
            end
          end
        end
        default: nxt = S_HUNT;
      endcase
    end
  end

  frame_buffer #(.AW(LOG2_LEN)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wp[LOG2_LEN-1:0]),
    .wdata (rxData),
    .re    (re),
    .raddr (raddr),
    .rdata (outData)
  );

  assign rxRead   = pop;
  assign outValid = (state == S_DRAIN);
  assign outLast  = (state == S_DRAIN) && last;
  assign frameOk  = ok_q;
  assign frameErr = err_q;
  assign errCode  = code_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Bench for rx_frame_parser: RxUart FIFO model feeds frames, scoreboard
// queues hold expected stream bytes and ok/err pulses, a monitor compares.
module tb_rx_frame_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x16BaudStrobe = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic       rxDataPresent = 1'b0;
  logic       outReady = 1'b1;
  logic       rxRead, outValid, outLast, frameOk, frameErr;
  logic [7:0] outData;
  logic [1:0] errCode;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo[$];
  logic [7:0] pl[$];
  logic [7:0] raw[$];
  logic [8:0] exp_data[$];
  logic [2:0] exp_evt[$];

  rx_frame_parser #(
    .LOG2_LEN (4),
    .SYNC     (8'h7E),
    .TIMEOUT  (16'd320)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .x16BaudStrobe (x16BaudStrobe),
    .rxData        (rxData),
    .rxDataPresent (rxDataPresent),
    .rxRead        (rxRead),
    .outData       (outData),
    .outValid      (outValid),
    .outLast       (outLast),
    .outReady      (outReady),
    .frameOk       (frameOk),
    .frameErr      (frameErr),
    .errCode       (errCode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  initial begin : strobe_gen
    int s;
    s = 0;
    forever begin
      @(negedge clk);
      s++;
      x16BaudStrobe = (s % 4 == 0);
    end
  end

  initial begin : rxuart_pop
    forever begin
      @(posedge clk);
      if (rxRead && !rst && fifo.size() > 0) void'(fifo.pop_front());
    end
  end

  initial begin : rxuart_view
    forever begin
      @(negedge clk);
      rxDataPresent = (fifo.size() > 0);
      rxData = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
  end

  initial begin : monitor
    logic       stall;
    logic [7:0] held;
    logic [8:0] e;
    logic [2:0] ev;
    stall = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 32'(outValid), 32'd1);
          check("hold_data", 32'(outData), 32'(held));
        end
        if (frameOk || frameErr) begin
          check("ok_err_excl", 32'(frameOk & frameErr), 32'd0);
          if (exp_evt.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL evt_unexpected ok=%0b err=%0b code=%0d t=%0t",
                     frameOk, frameErr, errCode, $time);
          end else begin
            ev = exp_evt.pop_front();
            check("evt_kind_err", 32'(frameErr), 32'(ev[2]));
            if (frameErr) check("err_code", 32'(errCode), 32'(ev[1:0]));
          end
        end
        if (outValid && outReady) begin
          if (exp_data.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL data_unexpected got=%0h last=%0b t=%0t",
                     outData, outLast, $time);
          end else begin
            e = exp_data.pop_front();
            check("out_data", 32'(outData), 32'(e[7:0]));
            check("out_last", 32'(outLast), 32'(e[8]));
          end
        end
        stall = outValid && !outReady;
        held = outData;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_raw();
    foreach (raw[i]) fifo.push_back(raw[i]);
  endtask

  // Good frame from pl: SYNC, LEN, payload, two's-complement checksum.
  task automatic push_good(input bit expect_data);
    logic [7:0] s;
    logic [7:0] n;
    n = 8'(pl.size());
    s = n;
    fifo.push_back(8'h7E);
    fifo.push_back(n);
    foreach (pl[i]) begin
      fifo.push_back(pl[i]);
      s = s + pl[i];
      if (expect_data)
        exp_data.push_back({(i == pl.size() - 1), pl[i]});
    end
    fifo.push_back(8'h00 - s);
    exp_evt.push_back(3'b000);
  endtask

  task automatic wait_done(input string name, input int budget,
                           input bit bp);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (bp) outReady = (i % 3 == 0);
      if (exp_data.size() == 0 && exp_evt.size() == 0
          && fifo.size() == 0 && !outValid) break;
    end
    outReady = 1'b1;
    checks++;
    if (i >= budget) begin
      failures++;
      $display("FAIL %s timeout data_left=%0d evt_left=%0d", name,
               exp_data.size(), exp_evt.size());
      exp_data.delete();
      exp_evt.delete();
      fifo.delete();
    end
    repeat (4) tick();
  endtask

  task automatic check_quiet(input string p);
    check({p, "_rxRead"}, 32'(rxRead), 32'd0);
    check({p, "_outValid"}, 32'(outValid), 32'd0);
    check({p, "_outLast"}, 32'(outLast), 32'd0);
    check({p, "_frameOk"}, 32'(frameOk), 32'd0);
    check({p, "_frameErr"}, 32'(frameErr), 32'd0);
    check({p, "_errCode"}, 32'(errCode), 32'd0);
    check({p, "_outData"}, 32'(outData), 32'd0);
  endtask

  initial begin : stim
    int n;
    #1;
    check_quiet("reset");
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // 1: good 3-byte frame, checksum 0x97
    pl = '{8'h11, 8'h22, 8'h33};
    push_good(1'b1);
    wait_done("t1_good", 400, 1'b0);

    // 2: bad checksum, then a 1-byte good frame (csum A5)
    raw = '{8'h7E, 8'h02, 8'hAA, 8'hBB, 8'h00};
    push_raw();
    exp_evt.push_back({1'b1, 2'd2});
    pl = '{8'h5A};
    push_good(1'b1);
    wait_done("t2_csum", 400, 1'b0);

    // 3: LEN 0, LEN 17, LEN==SYNC, then garbage before a good frame
    raw = '{8'h7E, 8'h00, 8'h7E, 8'h11, 8'h7E, 8'h7E};
    push_raw();
    exp_evt.push_back({1'b1, 2'd1});
    exp_evt.push_back({1'b1, 2'd1});
    exp_evt.push_back({1'b1, 2'd1});
    raw = '{8'h00, 8'hFF};
    push_raw();
    pl = '{8'h01};
    push_good(1'b1);
    wait_done("t3_len", 400, 1'b0);

    // 4: stall mid-payload until the inter-byte timeout expires
    raw = '{8'h7E, 8'h04, 8'h01};
    push_raw();
    exp_evt.push_back({1'b1, 2'd3});
    wait_done("t4_tmo", 3000, 1'b0);
    pl = '{8'hC0, 8'hFF, 8'hEE, 8'h00};
    push_good(1'b1);
    wait_done("t4_after", 400, 1'b0);

    // 5: max frame plus a queued second frame under backpressure
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'(i * 17 + 3));
    push_good(1'b1);
    pl = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84};
    push_good(1'b1);
    wait_done("t5_bp", 3000, 1'b1);

    // 6a: reset while in PAYLOAD
    raw = '{8'h7E, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
    push_raw();
    repeat (10) tick();
    rst = 1'b1;
    fifo.delete();
    #1;
    check_quiet("rst_payload");
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // 6b: reset while holding a drained byte
    outReady = 1'b0;
    pl = '{8'h10, 8'h20, 8'h30, 8'h40};
    push_good(1'b0);
    n = 0;
    while (!outValid && n < 200) begin
      tick();
      n++;
    end
    check("drain_reached", 32'(outValid), 32'd1);
    repeat (2) tick();
    rst = 1'b1;
    fifo.delete();
    #1;
    check_quiet("rst_drain");
    check("rst_drain_evt_left", 32'(exp_evt.size()), 32'd0);
    exp_evt.delete();
    repeat (2) tick();
    rst = 1'b0;
    outReady = 1'b1;
    repeat (2) tick();

    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h42, 8'h7E};
    push_good(1'b1);
    wait_done("t6_after", 400, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
